// File: rtl/sub_unit_32bit_if.sv
// Handshake and data bundle for the 32-bit multi-cycle subtractor.
// Ports: in_valid/in_ready + a/b (operand side), out_valid/out_ready +
// diff/borrow/zero/ovf (result side). slave = subtractor, master = its user.
interface sub_unit_32bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;
  logic        zero;
  logic        ovf;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zero, ovf
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zero, ovf
  );
endinterface

// File: rtl/sub_unit_32bit.sv
// Purpose: 32-bit a - b on one shared 16-bit lane, low half then high half.
// Latency: operands seen in IDLE are captured on that edge; out_valid rises after the third edge.
// Backpressure: single-entry; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports: clk, rst (sync, active-high); bus (sub_unit_32bit_if.slave):
//   in_valid/in_ready/a/b in, out_valid/out_ready/diff/borrow/zero/ovf out.
// Build option: define SUB_SAT_EN for unsigned saturating subtract
//   (diff forced to 0 whenever the result borrows).
module sub_unit_32bit #(
  parameter int LANE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  sub_unit_32bit_if.slave  bus
);

  localparam int DW = 2 * LANE_W;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t state, state_nxt;

  logic [DW-1:0]     a_r, b_r;
  logic [DW-1:0]     diff_r;
  logic              c_lo;
  logic              borrow_r, zero_r, ovf_r;

  logic [LANE_W-1:0] lane_x, lane_y;
  logic              lane_cin;
  logic [LANE_W:0]   lane_res;
  logic              in_ready_c, out_valid_c;

  logic [DW-1:0]     full_diff;
  logic              hi_borrow, hi_ovf;
  logic [DW-1:0]     res_diff;
  logic              res_ovf;

  // Ripple-lookahead lane: carry[i+1] = g | (p & carry[i]); sum = p ^ carry.
  // Returns {carry_out, sum}.
  function automatic logic [LANE_W:0] lane_add(input logic [LANE_W-1:0] x,
                                                input logic [LANE_W-1:0] y,
                                                input logic              cin);
    logic [LANE_W-1:0] p, g;
    logic [LANE_W:0]   c;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < LANE_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[LANE_W], p ^ c[LANE_W-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake outputs and lane operand select.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    lane_x      = '0;
    lane_y      = '0;
    lane_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = LO;
      end
      LO: begin
        // a - b == a + ~b + 1; the +1 enters as the low-half carry-in.
        lane_x    = a_r[LANE_W-1:0];
        lane_y    = ~b_r[LANE_W-1:0];
        lane_cin  = 1'b1;
        state_nxt = HI;
      end
      HI: begin
        lane_x    = a_r[DW-1:LANE_W];
        lane_y    = ~b_r[DW-1:LANE_W];
        lane_cin  = c_lo;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        // Accepting a new op here is deliberately deferred to IDLE.
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lane_res = lane_add(lane_x, lane_y, lane_cin);

  // High-pass result assembly; only meaningful while in HI.
  assign full_diff = {lane_res[LANE_W-1:0], diff_r[LANE_W-1:0]};
  // In subtraction the lane carry-out is "no borrow".
  assign hi_borrow = ~lane_res[LANE_W];
  assign hi_ovf    = (a_r[DW-1] != b_r[DW-1]) && (full_diff[DW-1] != a_r[DW-1]);

`ifdef SUB_SAT_EN
  assign res_diff = hi_borrow ? '0 : full_diff;
  assign res_ovf  = hi_borrow ? 1'b0 : hi_ovf;
`else
  assign res_diff = full_diff;
  assign res_ovf  = hi_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      diff_r   <= '0;
      c_lo     <= 1'b0;
      borrow_r <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r <= bus.a;
            b_r <= bus.b;
          end
        end
        LO: begin
          diff_r[LANE_W-1:0] <= lane_res[LANE_W-1:0];
          c_lo               <= lane_res[LANE_W];
        end
        HI: begin
          diff_r   <= res_diff;
          borrow_r <= hi_borrow;
          zero_r   <= (res_diff == '0);
          ovf_r    <= res_ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = diff_r;
  assign bus.borrow    = borrow_r;
  assign bus.zero      = zero_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_sub_unit_32bit.sv
// Directed bench for sub_unit_32bit: vector table plus backpressure and
// mid-operation reset sequences. Inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_sub_unit_32bit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sub_unit_32bit_if bus();

  sub_unit_32bit #(.LANE_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands in IDLE and count edges until out_valid (bounded).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int edges);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    step();
    edges        = 1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && edges < 12) begin
      step();
      edges++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int edges;

    vecs[0] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
`ifdef SUB_SAT_EN
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0005, 32'h0001_0003, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
`else
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0005, 32'h0001_0003, 32'hFFFF_0002, 1'b1, 1'b0, 1'b0};
`endif
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'hDEAD_BEEF, 32'h1111_1111, 32'hCD9C_ADDE, 1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    // Reset for two edges, then release.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("reset diff",      bus.diff,               32'd0);
    chk("reset borrow",    {31'd0, bus.borrow},    32'd0);
    chk("reset zero",      {31'd0, bus.zero},      32'd0);
    chk("reset ovf",       {31'd0, bus.ovf},       32'd0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d in_ready before", i), {31'd0, bus.in_ready}, 32'd1);
      issue(vecs[i].a, vecs[i].b, edges);
      chk($sformatf("vec%0d latency", i), edges, 32'd3);
      chk($sformatf("vec%0d diff", i),   bus.diff,               vecs[i].diff);
      chk($sformatf("vec%0d borrow", i), {31'd0, bus.borrow},    {31'd0, vecs[i].borrow});
      chk($sformatf("vec%0d zero", i),   {31'd0, bus.zero},      {31'd0, vecs[i].zero});
      chk($sformatf("vec%0d ovf", i),    {31'd0, bus.ovf},       {31'd0, vecs[i].ovf});
      chk($sformatf("vec%0d in_ready in done", i), {31'd0, bus.in_ready}, 32'd0);
      release_result();
      chk($sformatf("vec%0d out_valid after release", i), {31'd0, bus.out_valid}, 32'd0);
    end

    // Backpressure: hold the result while new operands are offered.
    issue(32'd10, 32'd3, edges);
    chk("bp first diff", bus.diff, 32'd7);
    bus.a         = 32'd100;
    bus.b         = 32'd1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp hold%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp hold%0d in_ready", i),  {31'd0, bus.in_ready},  32'd0);
      chk($sformatf("bp hold%0d diff", i),      bus.diff,               32'd7);
      chk($sformatf("bp hold%0d borrow", i),    {31'd0, bus.borrow},    32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp idle out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp idle in_ready",  {31'd0, bus.in_ready},  32'd1);
    // in_valid is still high: this edge takes the pending operands.
    step();
    edges        = 1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && edges < 12) begin
      step();
      edges++;
    end
    chk("bp second latency", edges, 32'd3);
    chk("bp second diff", bus.diff, 32'd99);
    release_result();

    // Reset while the high half is in flight.
    bus.a        = 32'd5;
    bus.b        = 32'd3;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("midrst diff",      bus.diff,               32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("midrst quiet%0d out_valid", i), {31'd0, bus.out_valid}, 32'd0);
    end

    // Block still works after the aborted op.
    issue(32'h0001_0000, 32'h0000_0001, edges);
    chk("post-reset latency", edges, 32'd3);
    chk("post-reset diff", bus.diff, 32'h0000_FFFF);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
